// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-side bus shared by the sequencer, program memory and decode
//   start          : begin fetching at the reset address (honoured in IDLE/HALT)
//   mem_add        : program-memory address, equal to the PC
//   mem_instruction: combinational memory read data for mem_add
//   instruction/pc : registered word handed to decode and the address it came from
//   valid/ready    : decode handshake, a transfer happens when both are high
//   redirect/_add  : execute-resolved jump or flush target
//   state/halted   : registered FSM state (IDLE=0 FETCH=1 WAIT_JUMP=2 HALT=3), halt flag
interface fetch_sequencer_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 29
);
   logic               start;
   logic [ADDR_W-1:0]  mem_add;
   logic [INSTR_W-1:0] mem_instruction;
   logic [INSTR_W-1:0] instruction;
   logic [ADDR_W-1:0]  pc;
   logic               valid;
   logic               ready;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_add;
   logic [1:0]         state;
   logic               halted;
   modport master (
      input  start, mem_instruction, ready, redirect, redirect_add,
      output mem_add, instruction, pc, valid, state, halted
   );
   modport slave (
      output start, mem_instruction, ready, redirect, redirect_add,
      input  mem_add, instruction, pc, valid, state, halted
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter owner that fetches words from program memory for decode
//   clk : single clock, all state changes on its rising edge
//   rst : synchronous active-high reset, highest priority
//   bus : fetch_sequencer_if master side (memory address/data, decode handshake,
//         execute redirect, start, registered state and halt flag)
module fetch_sequencer #(
   parameter int                 ADDR_W   = 8,
   parameter int                 INSTR_W  = 29,
   parameter int                 OPC_W    = 5,
   parameter logic [OPC_W-1:0]   JUMP_OPC = 5'b01010,
   parameter logic [OPC_W-1:0]   HALT_OPC = 5'b11111,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input logic               clk,
   input logic               rst,
   fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WAIT_JUMP = 2'd2, HALT = 2'd3} state_t;
   state_t             state;
   logic [ADDR_W-1:0]  pc_r;
   logic [INSTR_W-1:0] instr_r;
   logic [ADDR_W-1:0]  pc_out_r;
   logic               valid_r;
   logic               halted_r;
   logic               fetch;
   logic               drain;
   logic [OPC_W-1:0]   opc;
   assign opc   = bus.mem_instruction[INSTR_W-1 -: OPC_W];
   // The output slot can be refilled when empty or when decode takes it this cycle.
   assign fetch = state == FETCH && (!valid_r || bus.ready) && !bus.redirect;
   assign drain = valid_r && bus.ready;
   assign bus.mem_add     = pc_r;
   assign bus.instruction = instr_r;
   assign bus.pc          = pc_out_r;
   assign bus.valid       = valid_r;
   assign bus.state       = state;
   assign bus.halted      = halted_r;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc_r     <= RESET_PC;
         instr_r  <= '0;
         pc_out_r <= '0;
         valid_r  <= 1'b0;
         halted_r <= 1'b0;
      end else begin
         if (fetch) begin
            instr_r  <= bus.mem_instruction;
            pc_out_r <= pc_r;
            valid_r  <= 1'b1;
            pc_r     <= pc_r + 1'b1;
         end else if (drain) begin
            valid_r <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (bus.start) begin
                  pc_r  <= RESET_PC;
                  state <= FETCH;
               end
            end
            FETCH: begin
               // A redirect flushes the held word without a transfer.
               if (bus.redirect) begin
                  pc_r    <= bus.redirect_add;
                  valid_r <= 1'b0;
               end else if (fetch) begin
                  state    <= opc == JUMP_OPC ? WAIT_JUMP : opc == HALT_OPC ? HALT : FETCH;
                  halted_r <= opc == HALT_OPC;
               end
            end
            WAIT_JUMP: begin
               if (bus.redirect) begin
                  pc_r    <= bus.redirect_add;
                  valid_r <= 1'b0;
                  state   <= FETCH;
               end
            end
            HALT: begin
               if (bus.start) begin
                  pc_r     <= RESET_PC;
                  state    <= FETCH;
                  halted_r <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized check of fetch_sequencer against a slot-based model
module tb_fetch_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic [28:0] mem [0:255];
   int          total = 0;
   int          bad = 0;
   bit          en = 1'b0;
   int          m_state;
   logic [7:0]  m_pc;
   logic [7:0]  m_wpc;
   logic        m_v;
   logic [28:0] m_ins;
   logic [4:0]  op;
   int          r;
   fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(29)) bus ();
   fetch_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
   assign bus.mem_instruction = mem[bus.mem_add];
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
      end
   endtask
   task automatic step();
      @(negedge clk);
   endtask
   // Model: one output slot; decode empties it, then FETCH refills it from mem[PC].
   always @(posedge clk) begin
      if (rst) begin
         m_state = 0;
         m_pc    = 8'h00;
         m_v     = 1'b0;
         m_ins   = '0;
         m_wpc   = 8'h00;
      end else if (bus.redirect && (m_state == 1 || m_state == 2)) begin
         m_pc    = bus.redirect_add;
         m_v     = 1'b0;
         m_state = 1;
      end else begin
         if (m_v && bus.ready) m_v = 1'b0;
         if (m_state == 1 && !m_v) begin
            m_ins   = mem[m_pc];
            m_wpc   = m_pc;
            m_v     = 1'b1;
            m_pc    = m_pc + 8'd1;
            m_state = m_ins[28:24] == 5'b01010 ? 2 : m_ins[28:24] == 5'b11111 ? 3 : 1;
         end else if ((m_state == 0 || m_state == 3) && bus.start) begin
            m_pc    = 8'h00;
            m_state = 1;
         end
      end
   end
   always @(negedge clk) begin
      if (en) begin
         chk("model_mem_add", 32'(bus.mem_add), 32'(m_pc));
         chk("model_valid", 32'(bus.valid), 32'(m_v));
         chk("model_state", 32'(bus.state), 32'(m_state));
         chk("model_halted", 32'(bus.halted), 32'(m_state == 3));
         if (m_v) begin
            chk("model_instruction", 32'(bus.instruction), 32'(m_ins));
            chk("model_pc", 32'(bus.pc), 32'(m_wpc));
         end
      end
   end
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {5'(1 + i % 8), 24'(i * 24'h1357)};
      mem[0] = '0;
      mem[5] = {5'b01010, 24'h5};
      mem[6] = {5'b11111, 24'h6};
      rst = 1'b1;
      bus.start = 1'b0;
      bus.ready = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_add = '0;
      step();
      step();
      en = 1'b1;
      chk("rst_valid", 32'(bus.valid), 0);
      chk("rst_state", 32'(bus.state), 0);
      chk("rst_mem_add", 32'(bus.mem_add), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst_pc", 32'(bus.pc), 0);
      chk("rst_instruction", 32'(bus.instruction), 0);
      rst = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("start_state", 32'(bus.state), 1);
      chk("start_valid", 32'(bus.valid), 0);
      step();
      chk("first_valid", 32'(bus.valid), 1);
      chk("first_pc", 32'(bus.pc), 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("seq_pc", 32'(bus.pc), 32'(i));
      end
      step();
      chk("jump_pc", 32'(bus.pc), 5);
      chk("jump_state", 32'(bus.state), 2);
      step();
      chk("jump_drain_valid", 32'(bus.valid), 0);
      chk("jump_wait_state", 32'(bus.state), 2);
      bus.redirect = 1'b1;
      bus.redirect_add = 8'h0A;
      step();
      bus.redirect = 1'b0;
      chk("redir_state", 32'(bus.state), 1);
      chk("redir_mem_add", 32'(bus.mem_add), 32'h0A);
      step();
      chk("redir_pc", 32'(bus.pc), 32'h0A);
      chk("redir_valid", 32'(bus.valid), 1);
      bus.ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_pc", 32'(bus.pc), 32'h0A);
         chk("bp_instruction", 32'(bus.instruction), 32'(mem[10]));
         chk("bp_mem_add", 32'(bus.mem_add), 32'h0B);
      end
      bus.ready = 1'b1;
      step();
      chk("bp_release_pc", 32'(bus.pc), 32'h0B);
      bus.redirect = 1'b1;
      bus.redirect_add = 8'hFE;
      step();
      bus.redirect = 1'b0;
      chk("wrap_flush_valid", 32'(bus.valid), 0);
      step();
      chk("wrap_pc_fe", 32'(bus.pc), 32'hFE);
      step();
      chk("wrap_pc_ff", 32'(bus.pc), 32'hFF);
      step();
      chk("wrap_pc_00", 32'(bus.pc), 32'h00);
      chk("wrap_mem_add", 32'(bus.mem_add), 32'h01);
      bus.redirect = 1'b1;
      bus.redirect_add = 8'h06;
      step();
      bus.redirect = 1'b0;
      step();
      chk("halt_pc", 32'(bus.pc), 6);
      chk("halt_halted", 32'(bus.halted), 1);
      chk("halt_state", 32'(bus.state), 3);
      step();
      chk("halt_drain_valid", 32'(bus.valid), 0);
      bus.redirect = 1'b1;
      bus.redirect_add = 8'h33;
      step();
      bus.redirect = 1'b0;
      chk("halt_ignore_redir", 32'(bus.mem_add), 7);
      chk("halt_still", 32'(bus.state), 3);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("restart_state", 32'(bus.state), 1);
      chk("restart_mem_add", 32'(bus.mem_add), 0);
      step();
      chk("restart_pc", 32'(bus.pc), 0);
      chk("restart_valid", 32'(bus.valid), 1);
      bus.redirect = 1'b1;
      bus.redirect_add = 8'h05;
      step();
      bus.redirect = 1'b0;
      bus.ready = 1'b0;
      step();
      chk("wj_pc", 32'(bus.pc), 5);
      chk("wj_valid", 32'(bus.valid), 1);
      chk("wj_state", 32'(bus.state), 2);
      rst = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_add = 8'h44;
      step();
      chk("wj_rst_valid", 32'(bus.valid), 0);
      chk("wj_rst_state", 32'(bus.state), 0);
      chk("wj_rst_mem_add", 32'(bus.mem_add), 0);
      bus.redirect = 1'b0;
      for (int i = 0; i < 256; i++) begin
         r = $urandom_range(0, 19);
         op = r == 0 ? 5'b11111 : r < 3 ? 5'b01010 : 5'($urandom);
         mem[i] = {op, 24'($urandom)};
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         bus.start = $urandom_range(0, 4) == 0;
         bus.ready = $urandom_range(0, 3) != 0;
         bus.redirect = $urandom_range(0, 7) == 0;
         bus.redirect_add = 8'($urandom);
         rst = $urandom_range(0, 99) == 0;
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the 256 x 29-bit program memory for the processor pipeline. Owns the program counter, drives the memory's 8-bit address, registers each fetched word and hands it to decode over a valid/ready handshake. Stops fetching on a jump until execute supplies the register-held target, and halts on a halt opcode until restarted.

## Interface
Parameters:
- `ADDR_W`, 8: program-memory address width.
- `INSTR_W`, 29: instruction width.
- `OPC_W`, 5: opcode width. The opcode is `instruction[INSTR_W-1 -: OPC_W]`.
- `JUMP_OPC`, 5'b01010: opcode of the register jump.
- `HALT_OPC`, 5'b11111: opcode that stops fetching.
- `RESET_PC`, 0: start address after reset and on every `in_start`.

Ports:
- `in_clk`  input  1: the single clock. All state changes on its rising edge.
- `in_reset`  input  1: synchronous, active-high reset. It has priority over every other input.
- `in_start`  input  1: begin fetching at `RESET_PC`. Honoured only in IDLE and HALT.
- `out_mem_add`  output  ADDR_W: address to program memory, equal to the PC register.
- `in_mem_instruction`  input  INSTR_W: combinational read data from program memory for `out_mem_add`.
- `out_instruction`  output  INSTR_W: registered instruction presented to decode.
- `out_pc`  output  ADDR_W: address that `out_instruction` came from.
- `out_valid`  output  1: `out_instruction` and `out_pc` are valid.
- `in_ready`  input  1: decode accepts the word this cycle. A transfer happens when `out_valid && in_ready`.
- `in_redirect`  input  1: execute resolved a jump or flush.
- `in_redirect_add`  input  ADDR_W: new PC, valid with `in_redirect`.
- `out_state`  output  2: FSM state encoding, IDLE=0, FETCH=1, WAIT_JUMP=2, HALT=3.
- `out_halted`  output  1: high exactly when the FSM is in HALT.

## Operation
- The PC register drives `out_mem_add`. Memory read is combinational, so a word is captured the same cycle its address is presented.
- Fetch condition: `fetch = (state==FETCH) && (!out_valid || in_ready) && !in_redirect`.
- On `fetch`:
  - `out_instruction <= in_mem_instruction`
  - `out_pc <= PC`
  - `out_valid <= 1`
  - `PC <= PC+1`, modulo 2^ADDR_W, so 255 wraps to 0 with no flag.
- Fetched opcode == `JUMP_OPC`: the jump word is still issued, PC still increments, and the state goes to WAIT_JUMP.
- Fetched opcode == `HALT_OPC`: the halt word is still issued and the state goes to HALT.
- Any other opcode, including 0 (nop): the state stays FETCH.
- Drain: if `out_valid && in_ready` and no fetch occurs this cycle, `out_valid <= 0`.
- FSM transitions:
  - IDLE: on `in_start`, PC <= RESET_PC and go to FETCH. Otherwise stay.
  - FETCH: fetch as above. On `in_redirect`, PC <= `in_redirect_add`, `out_valid <= 0` (flush, no transfer counted), and stay in FETCH.
  - WAIT_JUMP: no fetch; the held word drains normally. On `in_redirect`, PC <= `in_redirect_add`, `out_valid <= 0`, and go to FETCH.
  - HALT: no fetch; the halt word drains normally. `in_redirect` is ignored. On `in_start`, PC <= RESET_PC and go to FETCH.
- `in_start` is ignored in FETCH and WAIT_JUMP.
- `in_redirect` is ignored in IDLE and HALT.
- Priority: `in_reset` > `in_redirect` > fetch/drain.

## Timing
- Reset values:
  - PC = RESET_PC, so `out_mem_add` = RESET_PC.
  - `out_instruction` = 0, `out_pc` = 0, `out_valid` = 0.
  - state = IDLE, `out_state` = 0, `out_halted` = 0.
- Reset in any state, including mid-fetch or WAIT_JUMP, discards the held word next edge.
- Start-to-first-valid: `in_start` at edge N gives FETCH after N; the word at RESET_PC is registered at N+1, so `out_valid` is high after N+1.
- Throughput: one instruction per cycle while `in_ready` stays high.
- Backpressure: while `out_valid && !in_ready`, `out_instruction`, `out_pc` and PC are held stable.
- Redirect latency: `in_redirect` at edge N sets PC after N. The word at the target is valid after N+1.
- `out_state` and `out_halted` are registered; `out_mem_add` follows PC with no extra delay.

## Test plan
- Reset then `in_start`, `in_ready`=1, memory {0: nop, 1..4: addi/add/addi/subi} -> `out_pc` sequence 0,1,2,3,4 on consecutive cycles, `out_valid` high from second edge after start.
- Jump word at address 5, `in_ready`=1 -> `out_pc`=5 issued, state=2, `out_valid` drops next cycle. Then `in_redirect`=1 with `in_redirect_add`=0x0A -> state=1, next `out_pc`=0x0A.
- `in_ready` held 0 for 3 cycles while word at address 2 is valid -> `out_instruction`/`out_pc` unchanged, `out_mem_add`=3 constant. Release -> next `out_pc`=3.
- PC at 0xFF in FETCH, `in_ready`=1 -> `out_pc` 0xFF then 0x00, no stall.
- Halt opcode at address 6 -> `out_halted`=1. `in_redirect` pulse is ignored (PC unchanged). `in_start` -> FETCH, `out_pc`=0 next valid.
- `in_reset` asserted in WAIT_JUMP with `out_valid`=1 -> next edge `out_valid`=0, state=0, `out_mem_add`=RESET_PC. Simultaneous `in_redirect` has no effect.
